ghash_acc: RTL and testbench
============================

// Module: ghash_acc
// PURPOSE
//   GHASH accumulation controller sitting directly upstream of gfmul.
//   Accepts a stream of 128-bit blocks (AAD || C || len(A)||len(C), caller-padded)
//   and computes Y_i = (Y_{i-1} ^ X_i) * H by driving gfmul.
//   Because each block depends on the previous product, it issues one product at
//   a time. It outputs Y after the last block (the GHASH tag before E_K(J0) xor).
// PARAMETERS
//   MUL_LAT  4   cycles from gfmul operand registers stable to oResult valid (>=1)
//   CNT_W    16  width of processed-block counter
// PORTS
//   clk         in   1      rising-edge clock
//   iRst        in   1      synchronous active-high reset
//   iStart      in   1      1-cycle pulse: latch iHashkey, clear Y, begin new message
//   iHashkey    in   128    hash subkey H (sampled only when iStart=1)
//   iValid      in   1      iBlock valid
//   iLast       in   1      qualifies iBlock as final block (length block)
//   iBlock      in   128    data block X_i (GCM bit order, MSB = coefficient x^0)
//   oReady      out  1      block can be accepted this cycle
//   oTag        out  128    final Y; held until next iStart/iRst
//   oTagValid   out  1      1 while oTag holds a completed result
//   oBlkCnt     out  CNT_W  blocks accepted since iStart
// BEHAVIOUR
//   Reset (iRst=1 at posedge): state=IDLE; Y, H, oTag=0; oReady=0, oTagValid=0,
//     oBlkCnt=0; any in-flight product is discarded (its result is never captured).
//   States: IDLE -> (iStart) ACCEPT -> (iValid&oReady) MUL -> (cnt==MUL_LAT-1)
//     ACCEPT, or DONE if the block carried iLast; DONE -> (iStart) ACCEPT.
//   oReady=1 only in ACCEPT. A block is accepted on the edge where iValid&oReady=1.
//     iValid while oReady=0 is ignored; the source holds the block until accepted.
//   On accept: mulA <= Y ^ iBlock, mulB = H (registered), cnt<=0, oBlkCnt+1,
//     last flag <= iLast. gfmul iCtext=mulA, iHashkey=mulB; operands stay constant
//     through MUL.
//   MUL: cnt increments each cycle; at cnt==MUL_LAT-1, Y <= gfmul oResult.
//   Throughput: one block per MUL_LAT+1 cycles (1 accept cycle + MUL_LAT).
//   Capture of the last block: oTag <= result, oTagValid<=1 in the same edge that
//     enters DONE.
//   iStart in any state (incl. MUL): aborts the current message. Next edge:
//     H<=iHashkey, Y<=0, oBlkCnt<=0, oTagValid<=0, state=ACCEPT.
//     The pending product is dropped. iRst has priority over iStart.
//   iStart with iValid in the same cycle: iStart wins, the block is not accepted.
//   iValid in IDLE/DONE: ignored. oBlkCnt saturates at 2^CNT_W-1 and does not wrap.
//   Empty message: the caller still supplies the length block with iLast, so
//     oTagValid always requires at least one block.
//   No internal XOR/shift of the data; bit ordering is exactly gfmul's.
// TESTING
//   1 Reset: drive iRst 2 cycles mid-MUL -> all outputs 0, IDLE; no spurious Y
//     capture after release.
//   2 Identity: H=b83b533708bf535d0aa6e52980d53b78, single block
//     80000000000000000000000000000000 with iLast -> oTag=H, oTagValid=1
//     exactly MUL_LAT+1 cycles after accept.
//   3 Zero: any H, single block 0 with iLast -> oTag=0, oBlkCnt=1.
//   4 Chain: H as in 2, blocks 8000..0 then 0 (iLast) -> oTag=H*H (bit-serial
//     software model). Then block 92cdf2c2ef434ea04ee66cc2189c7c1e alone ->
//     oTag=model(X,H). oReady low for MUL_LAT cycles between accepts.
//   5 Abort: iStart during MUL of a 3-block message, then 1 block 8000..0 with
//     iLast -> oTag=new H, oBlkCnt=1, stale product not merged.
//   6 Backpressure: iValid held high continuously over 4 blocks; the source
//     advances only on iValid&oReady -> oBlkCnt=4, oTag matches model.
//     iStart+iValid same cycle -> block not counted.

Source files
------------

// File: rtl/ghash_acc.sv
// ghash_acc: GHASH accumulator driving a pipelined GF(2^128) multiplier.
// Revision: 1.0
`default_nettype none

module gfmul #(
    parameter int unsigned LAT = 4
) (
    input  logic         clk,
    input  logic [127:0] iCtext,
    input  logic [127:0] iHashkey,
    output logic [127:0] oResult
);
    localparam logic [127:0] cPoly = {8'he1, 120'd0};

    logic [127:0] wProd;

    // GCM bit order: bit 127 is the x^0 coefficient, so shifting right multiplies by x.
    always_comb begin
        logic [127:0] z;
        logic [127:0] v;
        z = '0;
        v = iHashkey;
        for (int i = 0; i < 128; i++) begin
            if (iCtext[127 - i]) begin
                z = z ^ v;
            end
            v = v[0] ? ((v >> 1) ^ cPoly) : (v >> 1);
        end
        wProd = z;
    end

    // LAT-1 stages so the product is ready in time for the LAT-th edge after the operands settle.
    if (LAT > 1) begin : g_pipe
        logic [127:0] rStage [LAT-1];
        always_ff @(posedge clk) begin
            rStage[0] <= wProd;
            for (int i = 1; i < LAT - 1; i++) begin
                rStage[i] <= rStage[i - 1];
            end
        end
        assign oResult = rStage[LAT-2];
    end else begin : g_comb
        assign oResult = wProd;
    end
endmodule

module ghash_acc #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [127:0]     iHashkey,
    input  logic             iValid,
    input  logic             iLast,
    input  logic [127:0]     iBlock,
    output logic             oReady,
    output logic [127:0]     oTag,
    output logic             oTagValid,
    output logic [CNT_W-1:0] oBlkCnt
);
    localparam int unsigned CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    localparam logic [1:0] cIdle   = 2'd0;
    localparam logic [1:0] cAccept = 2'd1;
    localparam logic [1:0] cMul    = 2'd2;
    localparam logic [1:0] cDone   = 2'd3;

    logic [1:0]       rState;
    logic [127:0]     rY;
    logic [127:0]     rH;
    logic [127:0]     rMulA;
    logic [127:0]     rMulB;
    logic [CW-1:0]    rMulCnt;
    logic             rLast;
    logic [127:0]     rTag;
    logic             rTagValid;
    logic [CNT_W-1:0] rBlkCnt;
    logic [127:0]     wProd;

    gfmul #(
        .LAT (MUL_LAT)
    ) uMul (
        .clk      (clk),
        .iCtext   (rMulA),
        .iHashkey (rMulB),
        .oResult  (wProd)
    );

    always_ff @(posedge clk) begin
        if (iRst) begin
            rState    <= cIdle;
            rY        <= '0;
            rH        <= '0;
            rMulA     <= '0;
            rMulB     <= '0;
            rMulCnt   <= '0;
            rLast     <= 1'b0;
            rTag      <= '0;
            rTagValid <= 1'b0;
            rBlkCnt   <= '0;
        end else if (iStart) begin
            // Abort: the product in flight is dropped because we leave MUL.
            rState    <= cAccept;
            rH        <= iHashkey;
            rY        <= '0;
            rTag      <= '0;
            rTagValid <= 1'b0;
            rBlkCnt   <= '0;
        end else begin
            case (rState)
                cAccept: begin
                    if (iValid) begin
                        rMulA   <= rY ^ iBlock;
                        rMulB   <= rH;
                        rMulCnt <= '0;
                        rLast   <= iLast;
                        if (rBlkCnt != '1) begin
                            rBlkCnt <= rBlkCnt + CNT_W'(1);
                        end
                        rState  <= cMul;
                    end
                end
                cMul: begin
                    if (rMulCnt == CW'(MUL_LAT - 1)) begin
                        rY <= wProd;
                        if (rLast) begin
                            rTag      <= wProd;
                            rTagValid <= 1'b1;
                            rState    <= cDone;
                        end else begin
                            rState <= cAccept;
                        end
                    end else begin
                        rMulCnt <= rMulCnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign oReady    = (rState == cAccept);
    assign oTag      = rTag;
    assign oTagValid = rTagValid;
    assign oBlkCnt   = rBlkCnt;
endmodule

`default_nettype wire

// File: tb/tb_ghash_acc.sv
// tb_ghash_acc: directed checks of ghash_acc against hand values and a Horner-form GF model.
// Revision: 1.0
`default_nettype none

module tb_ghash_acc;
    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 16;
    localparam logic [127:0] cH   = 128'hb83b533708bf535d0aa6e52980d53b78;
    localparam logic [127:0] cOne = 128'h80000000000000000000000000000000;
    localparam logic [127:0] cX   = 128'h92cdf2c2ef434ea04ee66cc2189c7c1e;

    logic             clk = 1'b0;
    logic             iRst = 1'b1;
    logic             iStart = 1'b0;
    logic [127:0]     iHashkey = '0;
    logic             iValid = 1'b0;
    logic             iLast = 1'b0;
    logic [127:0]     iBlock = '0;
    logic             oReady;
    logic [127:0]     oTag;
    logic             oTagValid;
    logic [CNT_W-1:0] oBlkCnt;

    int nCmp = 0;
    int nBad = 0;

    ghash_acc #(
        .MUL_LAT (MUL_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iHashkey  (iHashkey),
        .iValid    (iValid),
        .iLast     (iLast),
        .iBlock    (iBlock),
        .oReady    (oReady),
        .oTag      (oTag),
        .oTagValid (oTagValid),
        .oBlkCnt   (oBlkCnt)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Multiply by x in GCM bit order.
    function automatic logic [127:0] mulX(input logic [127:0] v);
        return v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
    endfunction

    // Horner evaluation from the x^127 coefficient (bit 0) down to x^0 (bit 127).
    function automatic logic [127:0] gModel(input logic [127:0] x, input logic [127:0] h);
        logic [127:0] z;
        z = '0;
        for (int j = 0; j < 128; j++) begin
            z = mulX(z);
            if (x[j]) z = z ^ h;
        end
        return z;
    endfunction

    task automatic doStart(input logic [127:0] h);
        iStart   = 1'b1;
        iHashkey = h;
        @(negedge clk);
        iStart   = 1'b0;
    endtask

    task automatic sendBlock(input logic [127:0] x, input logic last, input logic hold);
        int n;
        iBlock = x;
        iLast  = last;
        iValid = 1'b1;
        n = 0;
        while (oReady !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkVal("readyTimeout", 128'd0, 128'd1);
        @(negedge clk);
        if (!hold) iValid = 1'b0;
    endtask

    task automatic waitTag(output int k);
        k = 0;
        while (oTagValid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        int gap;
        logic [127:0] y;
        logic [127:0] blk [4];
        blk[0] = 128'h0388dace60b6a392f328c2b971b2fe78;
        blk[1] = 128'h42831ec2217774244b7221b784d0d49c;
        blk[2] = 128'hdeadbeef00112233445566778899aabb;
        blk[3] = 128'h00000000000000000000000000000200;

        // Reset state, then iValid while idle must be ignored.
        repeat (2) @(negedge clk);
        iRst = 1'b0;
        @(negedge clk);
        checkVal("rstReady", oReady, 0);
        checkVal("rstTagValid", oTagValid, 0);
        checkVal("rstTag", oTag, 0);
        checkVal("rstBlkCnt", oBlkCnt, 0);
        iValid = 1'b1;
        repeat (3) @(negedge clk);
        iValid = 1'b0;
        checkVal("idleIgnore", oBlkCnt, 0);

        // Identity: 1 * H = H, with latency check.
        doStart(cH);
        sendBlock(cOne, 1'b1, 1'b0);
        checkVal("tvEarly", oTagValid, 0);
        waitTag(k);
        checkVal("latency", k + 1, MUL_LAT + 1);
        checkVal("identTag", oTag, cH);
        checkVal("identValid", oTagValid, 1);
        checkVal("identCnt", oBlkCnt, 1);

        // Zero block gives zero tag.
        doStart(128'h0123456789abcdeffedcba9876543210);
        checkVal("startClrValid", oTagValid, 0);
        sendBlock(128'd0, 1'b1, 1'b0);
        waitTag(k);
        checkVal("zeroValid", oTagValid, 1);
        checkVal("zeroTag", oTag, 0);
        checkVal("zeroCnt", oBlkCnt, 1);

        // Chain: (1*H ^ 0) * H = H*H; ready gap between accepts.
        doStart(cH);
        sendBlock(cOne, 1'b0, 1'b0);
        gap = 0;
        while (oReady !== 1'b1 && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        checkVal("readyGap", gap, MUL_LAT);
        sendBlock(128'd0, 1'b1, 1'b0);
        waitTag(k);
        checkVal("chainTag", oTag, gModel(cH, cH));
        checkVal("chainCnt", oBlkCnt, 2);

        doStart(cH);
        sendBlock(cX, 1'b1, 1'b0);
        waitTag(k);
        checkVal("xTag", oTag, gModel(cX, cH));

        // Abort during the third product, then a fresh one-block message.
        doStart(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        sendBlock(blk[0], 1'b0, 1'b0);
        sendBlock(blk[1], 1'b0, 1'b0);
        sendBlock(blk[2], 1'b0, 1'b0);
        doStart(cH);
        checkVal("abortCnt", oBlkCnt, 0);
        checkVal("abortReady", oReady, 1);
        sendBlock(cOne, 1'b1, 1'b0);
        waitTag(k);
        checkVal("abortTag", oTag, cH);
        checkVal("abortCntEnd", oBlkCnt, 1);

        // iStart with iValid: block not taken that edge; then held-valid stream.
        iStart   = 1'b1;
        iHashkey = cH;
        iValid   = 1'b1;
        iBlock   = blk[0];
        iLast    = 1'b0;
        @(negedge clk);
        iStart   = 1'b0;
        checkVal("startWinsCnt", oBlkCnt, 0);
        for (int i = 0; i < 4; i++) begin
            sendBlock(blk[i], (i == 3), (i != 3));
        end
        y = '0;
        for (int i = 0; i < 4; i++) y = gModel(y ^ blk[i], cH);
        waitTag(k);
        checkVal("bpValid", oTagValid, 1);
        checkVal("bpTag", oTag, y);
        checkVal("bpCnt", oBlkCnt, 4);

        // Reset mid-product: nothing captured afterwards.
        doStart(cH);
        sendBlock(cOne, 1'b1, 1'b0);
        iRst = 1'b1;
        repeat (2) @(negedge clk);
        iRst = 1'b0;
        checkVal("midRstReady", oReady, 0);
        checkVal("midRstCnt", oBlkCnt, 0);
        repeat (MUL_LAT + 3) @(negedge clk);
        checkVal("postRstValid", oTagValid, 0);
        checkVal("postRstTag", oTag, 0);
        checkVal("postRstReady", oReady, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL globalTimeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
